// File: rtl/sram_access_arbiter.sv
// Arbitrates the single-port SRAM controller between the latency-critical video reader
// and a small FIFO of buffered draw writes, with a read-burst cap to bound write starvation.
module sram_access_arbiter #(
    parameter int FIFO_AW        = 2,
    parameter int MAX_READ_BURST = 16,
    parameter int GUARD_CYCLES   = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        VID_REQ,
    input  logic [17:0] VID_ADDR,
    output logic        VID_ACK,
    output logic [15:0] VID_DATA,
    input  logic        WR_REQ,
    input  logic [17:0] WR_ADDR,
    input  logic [15:0] WR_DATA,
    output logic        WR_FULL,
    output logic        WR_OVERFLOW,
    output logic        SRAM_STARTWRITE,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DATAWRITTEN,
    input  logic [15:0] SRAM_DATAREAD,
    input  logic        SRAM_WRITEREADY
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BW    = $clog2(MAX_READ_BURST + 1);
    localparam int GW    = $clog2(GUARD_CYCLES + 2);

    localparam logic [FIFO_AW:0] DEPTH_CNT  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [BW-1:0]    BURST_MAX  = BW'(MAX_READ_BURST);
    localparam logic [GW-1:0]    GUARD_INIT = GW'(GUARD_CYCLES);

    typedef enum logic [1:0] {
        ST_GUARD,
        ST_IDLE,
        ST_WRITE
    } state_t;

    state_t            state_reg, state_next;
    logic [GW-1:0]     guard_reg, guard_next;
    logic [BW-1:0]     burst_reg, burst_next;

    logic [17:0]       fifo_addr_mem [DEPTH];
    logic [15:0]       fifo_data_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]  count_reg, count_next;

    logic [17:0]       hold_addr_reg;
    logic [15:0]       hold_data_reg;
    logic              vid_ack_reg;
    logic [15:0]       vid_data_reg;
    logic              overflow_reg;

    logic              fifo_empty, fifo_full, push;
    logic              read_grant, write_grant;
    logic              burst_at_max;
    logic [17:0]       head_addr;
    logic [15:0]       head_data;
    logic              startwrite_next;
    logic [17:0]       sram_addr_next;
    logic [15:0]       sram_data_next;

    assign fifo_empty   = (count_reg == '0);
    // Full is judged on the registered count, so a same-cycle pop never rescues a push.
    assign fifo_full    = (count_reg == DEPTH_CNT);
    assign push         = WR_REQ && !fifo_full;
    assign head_addr    = fifo_addr_mem[rd_ptr_reg];
    assign head_data    = fifo_data_mem[rd_ptr_reg];
    assign burst_at_max = (burst_reg == BURST_MAX);

    always_comb begin
        state_next      = state_reg;
        guard_next      = guard_reg;
        burst_next      = burst_reg;
        read_grant      = 1'b0;
        write_grant     = 1'b0;
        startwrite_next = 1'b0;
        sram_addr_next  = VID_ADDR;
        sram_data_next  = head_data;
        case (state_reg)
            ST_GUARD: begin
                // Counter is loaded with GUARD_CYCLES, giving exactly that many idle cycles.
                if (guard_reg <= GW'(1)) begin
                    guard_next = '0;
                    state_next = ST_IDLE;
                end else begin
                    guard_next = guard_reg - GW'(1);
                end
            end
            ST_IDLE: begin
                if (!fifo_empty && (!VID_REQ || burst_at_max)) begin
                    write_grant     = 1'b1;
                    startwrite_next = 1'b1;
                    sram_addr_next  = head_addr;
                    sram_data_next  = head_data;
                    burst_next      = '0;
                    state_next      = ST_WRITE;
                end else if (VID_REQ) begin
                    read_grant = 1'b1;
                    if (fifo_empty) begin
                        burst_next = '0;
                    end else if (!burst_at_max) begin
                        burst_next = burst_reg + BW'(1);
                    end
                end
            end
            ST_WRITE: begin
                sram_addr_next = hold_addr_reg;
                sram_data_next = hold_data_reg;
                if (SRAM_WRITEREADY) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_GUARD;
            end
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (push && !write_grant) begin
            count_next = count_reg + (FIFO_AW + 1)'(1);
        end else if (!push && write_grant) begin
            count_next = count_reg - (FIFO_AW + 1)'(1);
        end
    end

    // FIFO storage has no reset so it maps onto plain memory.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_reg] <= WR_ADDR;
            fifo_data_mem[wr_ptr_reg] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= ST_GUARD;
            guard_reg     <= GUARD_INIT;
            burst_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            hold_addr_reg <= '0;
            hold_data_reg <= '0;
            vid_ack_reg   <= 1'b0;
            vid_data_reg  <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            guard_reg   <= guard_next;
            burst_reg   <= burst_next;
            count_reg   <= count_next;
            vid_ack_reg <= read_grant;
            if (read_grant) begin
                vid_data_reg <= SRAM_DATAREAD;
            end
            if (WR_REQ && fifo_full) begin
                overflow_reg <= 1'b1;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
            end
            // The popped entry is held for the controller for the rest of the write.
            if (write_grant) begin
                rd_ptr_reg    <= rd_ptr_reg + FIFO_AW'(1);
                hold_addr_reg <= head_addr;
                hold_data_reg <= head_data;
            end
        end
    end

    assign VID_ACK          = vid_ack_reg;
    assign VID_DATA         = vid_data_reg;
    assign WR_FULL          = fifo_full;
    assign WR_OVERFLOW      = overflow_reg;
    assign SRAM_STARTWRITE  = startwrite_next;
    assign SRAM_ADDR        = sram_addr_next;
    assign SRAM_DATAWRITTEN = sram_data_next;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: a behavioural SRAM controller, a write scoreboard,
// a table of per-cycle vectors and hand-written multi-cycle sequences.
module tb_sram_access_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        VID_REQ;
    logic [17:0] VID_ADDR;
    logic        VID_ACK;
    logic [15:0] VID_DATA;
    logic        WR_REQ;
    logic [17:0] WR_ADDR;
    logic [15:0] WR_DATA;
    logic        WR_FULL;
    logic        WR_OVERFLOW;
    logic        SRAM_STARTWRITE;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DATAWRITTEN;
    logic [15:0] SRAM_DATAREAD;
    logic        SRAM_WRITEREADY;

    always #5 CLK = ~CLK;

    sram_access_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .VID_REQ(VID_REQ), .VID_ADDR(VID_ADDR), .VID_ACK(VID_ACK), .VID_DATA(VID_DATA),
        .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .WR_FULL(WR_FULL), .WR_OVERFLOW(WR_OVERFLOW),
        .SRAM_STARTWRITE(SRAM_STARTWRITE), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_DATAWRITTEN(SRAM_DATAWRITTEN), .SRAM_DATAREAD(SRAM_DATAREAD),
        .SRAM_WRITEREADY(SRAM_WRITEREADY)
    );

    int errors = 0;
    int checks = 0;
    int sw_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Controller model: STARTWRITE cycle plus three more, WRITEREADY in the last one.
    int         wcnt = 0;
    logic [7:0] lat_a;
    logic [15:0] lat_d;
    logic [15:0] mem [256];
    bit          written [256];

    function automatic logic [15:0] model_rd(input logic [17:0] a);
        if (written[a[7:0]]) return mem[a[7:0]];
        return {a[7:0], ~a[7:0]};
    endfunction

    assign SRAM_WRITEREADY = (wcnt == 3);
    assign SRAM_DATAREAD   = (wcnt != 0) ? 16'hDEAD : model_rd(SRAM_ADDR);

    always @(posedge CLK) begin
        if (wcnt == 0) begin
            if (SRAM_STARTWRITE === 1'b1) begin
                wcnt  <= 1;
                lat_a <= SRAM_ADDR[7:0];
                lat_d <= SRAM_DATAWRITTEN;
            end
        end else if (wcnt == 3) begin
            mem[lat_a]     <= lat_d;
            written[lat_a] <= 1'b1;
            wcnt           <= 0;
        end else begin
            wcnt <= wcnt + 1;
        end
    end

    // Scoreboard: accepted pushes queued at drive time, popped on each STARTWRITE.
    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
    } wr_t;
    wr_t exp_wr_q[$];

    logic [15:0] rd_exp;
    always @(posedge CLK) rd_exp <= model_rd(VID_ADDR);

    always @(negedge CLK) begin
        if (SRAM_STARTWRITE === 1'b1) begin
            sw_count++;
            if (exp_wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         SRAM_ADDR, SRAM_DATAWRITTEN);
            end else begin
                wr_t e;
                e = exp_wr_q.pop_front();
                chk("sb_wr_addr", 32'(SRAM_ADDR), 32'(e.a));
                chk("sb_wr_data", 32'(SRAM_DATAWRITTEN), 32'(e.d));
            end
        end
        if (VID_ACK === 1'b1) chk("sb_rd_data", 32'(VID_DATA), 32'(rd_exp));
    end

    logic        s_ack, s_sw, s_full, s_ovf;
    logic [15:0] s_vdata;

    task automatic step();
        @(negedge CLK);
        s_ack   = VID_ACK;
        s_sw    = SRAM_STARTWRITE;
        s_full  = WR_FULL;
        s_ovf   = WR_OVERFLOW;
        s_vdata = VID_DATA;
        @(posedge CLK);
        #1;
    endtask

    task automatic push_wr(input logic [17:0] a, input logic [15:0] d, input bit accept);
        wr_t e;
        WR_REQ  = 1'b1;
        WR_ADDR = a;
        WR_DATA = d;
        e.a = a;
        e.d = d;
        if (accept) exp_wr_q.push_back(e);
    endtask

    typedef struct {
        logic        vreq;
        logic [17:0] vaddr;
        logic        wreq;
        logic [17:0] waddr;
        logic [15:0] wdata;
        logic        ack;
        logic        sw;
        logic        full;
        logic        chkd;
        logic [15:0] vdata;
    } vec_t;

    function automatic vec_t mk(bit vreq, int vaddr, bit wreq, int waddr, int wdata,
                                bit ack, bit sw, bit full, bit chkd, int vdata);
        vec_t v;
        v.vreq = vreq;  v.vaddr = 18'(vaddr);
        v.wreq = wreq;  v.waddr = 18'(waddr);  v.wdata = 16'(wdata);
        v.ack  = ack;   v.sw    = sw;          v.full  = full;
        v.chkd = chkd;  v.vdata = 16'(vdata);
        return v;
    endfunction

    vec_t tbl [16];

    initial begin
        int n;
        int sw_base;
        bit full_seen;
        bit ack_gap;

        // Guard window, back-to-back reads, then a single buffered write and read-back.
        tbl[0]  = mk(1, 'h01, 0, 0, 0,          0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 'h02, 0, 0, 0,          0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 'h03, 0, 0, 0,          0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 'h04, 0, 0, 0,          0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 'h05, 0, 0, 0,          1, 0, 0, 1, 'h04FB);
        tbl[5]  = mk(1, 'h06, 0, 0, 0,          1, 0, 0, 1, 'h05FA);
        tbl[6]  = mk(0, 'h06, 0, 0, 0,          1, 0, 0, 1, 'h06F9);
        tbl[7]  = mk(0, 'h00, 0, 0, 0,          0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 'h00, 1, 'h10, 'hBEEF,  0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 'h00, 0, 0, 0,          0, 1, 0, 0, 0);
        tbl[10] = mk(0, 'h00, 0, 0, 0,          0, 0, 0, 0, 0);
        tbl[11] = mk(0, 'h00, 0, 0, 0,          0, 0, 0, 0, 0);
        tbl[12] = mk(1, 'h10, 0, 0, 0,          0, 0, 0, 0, 0);
        tbl[13] = mk(1, 'h10, 0, 0, 0,          0, 0, 0, 0, 0);
        tbl[14] = mk(0, 'h10, 0, 0, 0,          1, 0, 0, 1, 'hBEEF);
        tbl[15] = mk(0, 'h00, 0, 0, 0,          0, 0, 0, 0, 0);

        RESET = 1'b1; VID_REQ = 1'b0; VID_ADDR = '0;
        WR_REQ = 1'b0; WR_ADDR = '0; WR_DATA = '0;
        @(posedge CLK);
        #1;
        chk("reset_ack",      32'(VID_ACK), 0);
        chk("reset_vdata",    32'(VID_DATA), 0);
        chk("reset_overflow", 32'(WR_OVERFLOW), 0);
        chk("reset_startwr",  32'(SRAM_STARTWRITE), 0);
        chk("reset_full",     32'(WR_FULL), 0);
        RESET = 1'b0;

        for (int i = 0; i < 16; i++) begin
            VID_REQ  = tbl[i].vreq;
            VID_ADDR = tbl[i].vaddr;
            WR_REQ   = 1'b0;
            if (tbl[i].wreq) push_wr(tbl[i].waddr, tbl[i].wdata, !tbl[i].full);
            step();
            chk($sformatf("row%0d_ack", i),  32'(s_ack),  32'(tbl[i].ack));
            chk($sformatf("row%0d_sw", i),   32'(s_sw),   32'(tbl[i].sw));
            chk($sformatf("row%0d_full", i), 32'(s_full), 32'(tbl[i].full));
            if (tbl[i].chkd) chk($sformatf("row%0d_vdata", i), 32'(s_vdata), 32'(tbl[i].vdata));
        end
        WR_REQ = 1'b0;

        // Continuous video with one queued write: 16 reads, then a forced write.
        VID_REQ = 1'b1; VID_ADDR = 18'h30;
        push_wr(18'h40, 16'h4444, 1);
        step();
        WR_REQ = 1'b0;
        full_seen = s_full;
        ack_gap = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            VID_ADDR = 18'(18'h30 + n);
            step();
            full_seen |= s_full;
            if (!s_ack) ack_gap = 1'b1;
            if (s_sw) break;
            n++;
        end
        chk("burst_reads_before_write", 32'(n), 16);
        chk("burst_ack_continuous", 32'(ack_gap), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            full_seen |= s_full;
            chk($sformatf("burst_stall%0d_ack", k), 32'(s_ack), 0);
        end
        step();
        chk("burst_ack_resumes", 32'(s_ack), 1);
        chk("burst_full_never", 32'(full_seen), 0);

        // Five pushes against a busy video client: fifth is dropped.
        for (int i = 0; i < 5; i++) begin
            push_wr(18'(18'h50 + i), 16'(16'h5000 + i), i < 4);
            step();
            chk($sformatf("ovf_push%0d_full", i), 32'(s_full), 32'(i == 4));
            chk($sformatf("ovf_push%0d_sticky", i), 32'(s_ovf), 0);
        end
        WR_REQ = 1'b0; VID_REQ = 1'b0;
        sw_base = sw_count;
        step();
        chk("ovf_sticky_set", 32'(s_ovf), 1);
        for (int k = 0; k < 24; k++) step();
        chk("ovf_write_count", 32'(sw_count - sw_base), 4);
        chk("ovf_queue_drained", 32'(exp_wr_q.size()), 0);
        chk("ovf_still_set", 32'(s_ovf), 1);

        // Push and pop in one cycle at count 2; fullness tracks the unchanged count.
        VID_REQ = 1'b1; VID_ADDR = 18'h60;
        push_wr(18'h61, 16'h6100, 1); step();
        chk("pp_c1_sw", 32'(s_sw), 0);
        push_wr(18'h62, 16'h6200, 1); step();
        chk("pp_c2_sw", 32'(s_sw), 0);
        VID_REQ = 1'b0;
        push_wr(18'h63, 16'h6300, 1); step();
        chk("pp_c3_sw", 32'(s_sw), 1);
        push_wr(18'h64, 16'h6400, 1); step();
        chk("pp_c4_full", 32'(s_full), 0);
        push_wr(18'h65, 16'h6500, 1); step();
        chk("pp_c5_full", 32'(s_full), 0);
        WR_REQ = 1'b0; step();
        chk("pp_c6_full", 32'(s_full), 1);
        for (int k = 0; k < 24; k++) step();
        chk("pp_queue_drained", 32'(exp_wr_q.size()), 0);

        // Reset in the second cycle of a write: guard, then the write's data reads back.
        push_wr(18'h20, 16'h1234, 1); step();
        WR_REQ = 1'b0; step();
        chk("rw_start_sw", 32'(s_sw), 1);
        RESET = 1'b1; step();
        RESET = 1'b0; VID_REQ = 1'b1; VID_ADDR = 18'h20;
        sw_base = sw_count;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rw_guard%0d_sw", k), 32'(s_sw), 0);
            chk($sformatf("rw_guard%0d_ack", k), 32'(s_ack), 0);
            if (k == 0) chk("rw_overflow_cleared", 32'(s_ovf), 0);
        end
        step();
        chk("rw_first_ack", 32'(s_ack), 1);
        chk("rw_first_data", 32'(s_vdata), 32'h1234);
        VID_REQ = 1'b0;
        for (int k = 0; k < 8; k++) step();
        chk("rw_no_reissue", 32'(sw_count - sw_base), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
